// File: rtl/gf163_mult_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : gf163_mult_ctrl_if
// Brief    : Request/result bundle between a client and the GF(2^163) multiplier.
// Revision : 1.0
// ============================================================================
interface gf163_mult_ctrl_if;
    logic         start;
    logic [162:0] a;
    logic [162:0] b;
    logic         busy;
    logic         done;
    logic [162:0] c;

    modport master (output start, a, b, input busy, done, c);
    modport slave  (input start, a, b, output busy, done, c);
endinterface
`default_nettype wire

// File: rtl/gf163_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gf163_mult_ctrl
// Brief    : Digit-serial GF(2^163) multiplier, 5x5 digit schedule over one
//            40x40 carry-less core, single-cycle fold mod x^163+x^7+x^6+x^3+1.
// Revision : 1.0
// ============================================================================
module gf163_mult40 (
    input  logic [39:0] x,
    input  logic [39:0] y,
    output logic [79:0] p
);
    always_comb begin
        p = '0;
        for (int k = 0; k < 40; k++) begin
            if (y[k]) begin
                p = p ^ ({40'd0, x} << k);
            end
        end
    end
endmodule

module gf163_mult_ctrl (
    input  logic             clk,
    input  logic             rst_n,
    gf163_mult_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        REDUCE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [199:0] a_reg;
    logic [199:0] b_reg;
    logic [399:0] acc;
    logic [2:0]   i_cnt;
    logic [2:0]   j_cnt;
    logic         last_pp;

    logic [39:0]  a_dig;
    logic [39:0]  b_dig;
    logic [79:0]  pp;
    logic [3:0]   dig_sum;
    logic [399:0] pp_shift;

    logic [161:0] hi1;
    logic [169:0] fold1;
    logic [6:0]   hi2;
    logic [162:0] reduced;

    assign last_pp  = (i_cnt == 3'd4) && (j_cnt == 3'd4);
    assign a_dig    = a_reg[i_cnt * 8'd40 +: 40];
    assign b_dig    = b_reg[j_cnt * 8'd40 +: 40];
    assign dig_sum  = {1'b0, i_cnt} + {1'b0, j_cnt};
    assign pp_shift = {320'd0, pp} << (dig_sum * 9'd40);

    gf163_mult40 u_mult40 (
        .x (a_dig),
        .y (b_dig),
        .p (pp)
    );

    // x^163 == x^7 + x^6 + x^3 + 1; first fold leaves degree <= 168, second clears it.
    assign hi1   = acc[324:163];
    assign fold1 = {7'd0, acc[162:0]} ^ {8'd0, hi1} ^ {5'd0, hi1, 3'd0}
                 ^ {2'd0, hi1, 6'd0} ^ {1'd0, hi1, 7'd0};
    assign hi2   = fold1[169:163];
    assign reduced = fold1[162:0] ^ {156'd0, hi2} ^ {153'd0, hi2, 3'd0}
                   ^ {150'd0, hi2, 6'd0} ^ {149'd0, hi2, 7'd0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = MULT;
            MULT:    if (last_pp)   state_next = REDUCE;
            REDUCE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            i_cnt    <= '0;
            j_cnt    <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.c    <= '0;
        end else begin
            // Zero-padded operands keep the unreduced product below x^325.
            assert (acc[399:325] == 75'd0);
            bus.busy <= (state_next != IDLE);
            bus.done <= (state == REDUCE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg <= {37'd0, bus.a};
                        b_reg <= {37'd0, bus.b};
                        acc   <= '0;
                        i_cnt <= '0;
                        j_cnt <= '0;
                    end
                end
                MULT: begin
                    acc <= acc ^ pp_shift;
                    if (j_cnt == 3'd4) begin
                        j_cnt <= '0;
                        i_cnt <= last_pp ? 3'd0 : i_cnt + 3'd1;
                    end else begin
                        j_cnt <= j_cnt + 3'd1;
                    end
                end
                REDUCE: begin
                    bus.c <= reduced;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_gf163_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf163_mult_ctrl
// Brief    : Randomized self-checking bench against a bit-serial GF(2^163) model.
// Revision : 1.0
// ============================================================================
module tb_gf163_mult_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gf163_mult_ctrl_if bus ();

    gf163_mult_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [162:0] got, input logic [162:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Horner-style shift-and-add, reducing whenever x^163 appears.
    function automatic logic [162:0] ref_mul(input logic [162:0] x, input logic [162:0] y);
        logic [163:0] r;
        logic [163:0] poly;
        r = '0;
        poly = '0;
        poly[163] = 1'b1;
        poly[7:0] = 8'hC9;
        for (int k = 162; k >= 0; k--) begin
            r = r << 1;
            if (r[163]) r = r ^ poly;
            if (y[k]) r = r ^ {1'b0, x};
        end
        return r[162:0];
    endfunction

    function automatic logic [162:0] rnd163();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[162:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [162:0] x, input logic [162:0] y, input string tag);
        int  n;
        bit  found;
        logic [162:0] exp;
        exp = ref_mul(x, y);
        bus.a = x;
        bus.b = y;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, "_busy"}, 163'(bus.busy), 163'd1);
        n = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            tick();
            n++;
            if (bus.done) found = 1'b1;
        end
        check({tag, "_lat"}, 163'(n), 163'd26);
        check({tag, "_c"}, bus.c, exp);
        check({tag, "_idle"}, 163'(bus.busy), 163'd0);
        check({tag, "_acchi"}, 163'(dut.acc[399:325]), 163'd0);
        tick();
        check({tag, "_done0"}, 163'(bus.done), 163'd0);
        check({tag, "_hold"}, bus.c, exp);
    endtask

    logic [162:0] sp [7];

    initial begin
        logic [162:0] x;
        logic [162:0] y;
        logic [162:0] exp;
        int           done_cnt;
        int           done_edge;
        logic [162:0] done_c;
        int           held_edges [$];
        logic [162:0] held_c [$];

        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_busy", 163'(bus.busy), 163'd0);
        check("rst_done", 163'(bus.done), 163'd0);
        check("rst_c", bus.c, 163'd0);

        run_op(163'd1, 163'd1, "one");
        run_op(163'h2, 163'h3, "two_three");
        x = '0;
        x[162] = 1'b1;
        run_op(x, 163'h2, "x162");
        check("x162_val", bus.c, 163'hC9);

        // Starts at E5 and E26 must be dropped.
        x = rnd163();
        y = rnd163();
        exp = ref_mul(x, y);
        bus.a = x;
        bus.b = y;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        done_cnt = 0;
        done_edge = 0;
        done_c = '0;
        for (int n = 1; n <= 60; n++) begin
            if (n == 5 || n == 26) begin
                bus.a = rnd163();
                bus.b = rnd163();
                bus.start = 1'b1;
            end
            tick();
            bus.start = 1'b0;
            if (bus.done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_edge = n;
                    done_c = bus.c;
                end
            end
        end
        check("ign_cnt", 163'(done_cnt), 163'd1);
        check("ign_edge", 163'(done_edge), 163'd26);
        check("ign_c", done_c, exp);

        // Continuous start: back-to-back operations every 27 edges.
        x = rnd163() | 163'd1;
        y = rnd163() | 163'd1;
        exp = ref_mul(x, y);
        bus.a = x;
        bus.b = y;
        bus.start = 1'b1;
        tick();
        for (int n = 1; n <= 80; n++) begin
            tick();
            if (bus.done) begin
                held_edges.push_back(n);
                held_c.push_back(bus.c);
            end
        end
        bus.start = 1'b0;
        check("held_cnt", 163'(held_edges.size()), 163'd3);
        if (held_edges.size() == 3) begin
            check("held_e0", 163'(held_edges[0]), 163'd26);
            check("held_e1", 163'(held_edges[1]), 163'd53);
            check("held_e2", 163'(held_edges[2]), 163'd80);
            for (int k = 0; k < 3; k++) check("held_c", held_c[k], exp);
        end
        repeat (30) tick();

        // Asynchronous reset in the middle of an operation.
        bus.a = rnd163();
        bus.b = rnd163();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("arst_busy", 163'(bus.busy), 163'd0);
        check("arst_done", 163'(bus.done), 163'd0);
        check("arst_c", bus.c, 163'd0);
        tick();
        tick();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (bus.done) done_cnt++;
        end
        check("arst_nodone", 163'(done_cnt), 163'd0);
        run_op(163'd1, 163'd1, "post_rst");

        // Boundary operands against each other, then random pairs.
        sp[0] = '1;
        sp[1] = 163'd1 << 39;
        sp[2] = 163'd1 << 40;
        sp[3] = 163'd1 << 159;
        sp[4] = 163'd1 << 160;
        sp[5] = 163'd1 << 162;
        sp[6] = 163'd1;
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 7; j++) begin
                run_op(sp[i], sp[j], "special");
            end
        end
        for (int k = 0; k < 951; k++) begin
            x = rnd163();
            y = rnd163();
            if ($urandom_range(0, 7) == 0) x = sp[$urandom_range(0, 6)];
            if ($urandom_range(0, 7) == 0) y = sp[$urandom_range(0, 6)];
            run_op(x, y, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
